seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter: the stimulus end of the serial sequence recognizer interface.
//  Accepts a bit pattern, its length and a repeat count over a valid/ready handshake.
//  Shifts the pattern out MSB-first, one bit per clk, on a single-bit line (x_out).
//  Sits upstream of the recognizer in self-test and link-bring-up paths.
// PARAMETERS
//  PAT_W    8  max pattern length in bits (>=2)
//  RPT_W    4  width of repeat-count field
//  GAP_CYC  0  idle cycles inserted between repetitions (0 = back-to-back)
//  IDLE_LVL 0  level driven on x_out when no bit is valid
// PORTS
//  clk        in   1                clock, rising edge
//  reset      in   1                synchronous, active-high
//  in_valid   in   1                request valid
//  in_ready   out  1                block can accept request
//  in_pattern in   PAT_W            pattern; bit [in_len-1] is sent first
//  in_len     in   $clog2(PAT_W+1)  bits per pass; 0 or >PAT_W means PAT_W
//  in_repeat  in   RPT_W            extra passes; total passes = in_repeat+1
//  abort      in   1                cancel current transfer
//  x_out      out  1                serial data line to recognizer X input
//  x_valid    out  1                x_out carries a pattern bit this cycle
//  busy       out  1                transfer in progress (SHIFT/GAP/DONE)
//  done       out  1                one-cycle pulse, transfer completed normally
// BEHAVIOUR
//  - Clock clk; reset is synchronous, active-high. All outputs registered.
//  - Reset values: in_ready=1, x_out=IDLE_LVL, x_valid=0, busy=0, done=0; FSM=IDLE.
//    Reset asserted mid-transfer wins over everything; the transfer is dropped, no done.
//  - FSM states: IDLE, SHIFT, GAP, DONE.
//  - IDLE: in_ready=1. Accept on in_valid&&in_ready at edge T: latch pattern, eff_len, passes.
//    -> SHIFT. in_ready=0 from T+1. x_out=bit[eff_len-1], x_valid=1 at T+1.
//  - SHIFT: bit index counts eff_len-1 down to 0, one bit per cycle.
//    After bit 0: passes left & GAP_CYC>0 -> GAP; passes left & GAP_CYC=0 -> SHIFT,
//    restarting at bit[eff_len-1] with no bubble; no passes left -> DONE.
//  - GAP: exactly GAP_CYC cycles with x_valid=0, x_out=IDLE_LVL, then -> SHIFT.
//  - DONE: one cycle, done=1, x_valid=0, busy=1. -> IDLE (in_ready=1 next cycle).
//  - Latency: last bit of a single pass of length L appears at T+L; done at T+L+1.
//  - Total cycles from accept to done: (in_repeat+1)*eff_len + in_repeat*GAP_CYC + 1.
//  - in_valid while not in_ready: ignored; no queueing; input fields not sampled.
//  - abort (any non-IDLE state): next edge -> IDLE, x_valid=0, x_out=IDLE_LVL, no done.
//    abort in IDLE has no effect. If abort and in_valid are both high in IDLE, abort wins:
//    the request is not accepted.
//  - Repeat counter and bit index are internal, saturate-free, and reload on each accept.
//  - x_out holds IDLE_LVL whenever x_valid=0, so a downstream recognizer sees a defined level.
// TESTING
//  1. pattern=8'b101, len=3, rpt=0, accept@T -> x_out 1,0,1 at T+1..T+3, x_valid=1;
//     done@T+4. The downstream recognizer output goes 1 after the last bit.
//  2. pattern=8'b0110, len=4, rpt=2, GAP_CYC=2 -> 0110,--,0110,--,0110; gaps x_valid=0;
//     done 17 cycles after accept.
//  3. len=0, pattern=8'hA5 -> all 8 bits sent MSB-first (1,0,1,0,0,1,0,1); done@T+9.
//  4. abort at 2nd bit of a len=6 transfer -> next cycle x_valid=0, in_ready=1, no done pulse;
//     then a new request is accepted normally.
//  5. reset at 3rd bit of a len=5 transfer -> next cycle all outputs at reset values.
//     A request held on in_valid while busy is not accepted until IDLE.
//  6. rpt=1, GAP_CYC=0, pattern=2'b10, len=2 -> x_out 1,0,1,0 with x_valid continuously 1;
//     done@T+5.

Source files
------------

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_tx
//  Description : Serial pattern transmitter. It accepts a pattern, a length
//                and a repeat count over a valid/ready handshake. It shifts
//                the pattern out MSB-first, one bit per clock, optionally
//                with idle gaps between repetitions.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int PAT_W    = 8,
    parameter int RPT_W    = 4,
    parameter int GAP_CYC  = 0,
    parameter int IDLE_LVL = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PAT_W-1:0]             in_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   in_len,
    input  logic [RPT_W-1:0]             in_repeat,
    input  logic                         abort,
    output logic                         x_out,
    output logic                         x_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [LEN_W-1:0] c_max_len  = LEN_W'(PAT_W);
    localparam logic             c_idle_lvl = (IDLE_LVL != 0);
    localparam logic [GAP_W-1:0] c_gap_load = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [PAT_W-1:0]   r_pat,  w_pat_nx;
    logic [LEN_W-1:0]   r_len,  w_len_nx;
    logic [LEN_W-1:0]   r_idx,  w_idx_nx;
    logic [RPT_W-1:0]   r_pass, w_pass_nx;
    logic [GAP_W-1:0]   r_gap,  w_gap_nx;
    logic               w_bit_valid;
    logic [LEN_W-1:0]   w_eff_len;
    logic [PAT_W-1:0]   w_shifted;

    // A zero or oversized length request means "send the full pattern width".
    assign w_eff_len = ((in_len == '0) || (in_len > c_max_len)) ? c_max_len : in_len;

    // The bit driven next cycle is taken from whichever pattern will be held
    // next cycle, so a freshly accepted pattern appears on the line at once.
    assign w_shifted = w_pat_nx >> w_idx_nx;

    // Next-state, next-index and repeat bookkeeping.
    always_comb begin
        w_state_nx  = r_state;
        w_pat_nx    = r_pat;
        w_len_nx    = r_len;
        w_idx_nx    = r_idx;
        w_pass_nx   = r_pass;
        w_gap_nx    = r_gap;
        w_bit_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort outranks a simultaneous request
                if (in_valid && !abort) begin
                    w_state_nx  = S_SHIFT;
                    w_pat_nx    = in_pattern;
                    w_len_nx    = w_eff_len;
                    w_idx_nx    = w_eff_len - LEN_W'(1);
                    w_pass_nx   = in_repeat;
                    w_bit_valid = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (r_idx == '0) begin
                    if (r_pass != '0) begin
                        w_pass_nx = r_pass - RPT_W'(1);
                        if (GAP_CYC > 0) begin
                            w_state_nx = S_GAP;
                            w_gap_nx   = c_gap_load;
                        end else begin
                            // back-to-back repetition, no bubble
                            w_idx_nx    = r_len - LEN_W'(1);
                            w_bit_valid = 1'b1;
                        end
                    end else begin
                        w_state_nx = S_DONE;
                    end
                end else begin
                    w_idx_nx    = r_idx - LEN_W'(1);
                    w_bit_valid = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                end else if (r_gap == '0) begin
                    w_state_nx  = S_SHIFT;
                    w_idx_nx    = r_len - LEN_W'(1);
                    w_bit_valid = 1'b1;
                end else begin
                    w_gap_nx = r_gap - GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pat    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_pass   <= '0;
            r_gap    <= '0;
            in_ready <= 1'b1;
            x_out    <= c_idle_lvl;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pat    <= w_pat_nx;
            r_len    <= w_len_nx;
            r_idx    <= w_idx_nx;
            r_pass   <= w_pass_nx;
            r_gap    <= w_gap_nx;
            in_ready <= (w_state_nx == S_IDLE);
            busy     <= (w_state_nx != S_IDLE);
            done     <= (w_state_nx == S_DONE);
            x_valid  <= w_bit_valid;
            x_out    <= w_bit_valid ? w_shifted[0] : c_idle_lvl;
        end
    end

endmodule
`default_nettype wire
